// File: rtl/unmixsx32_pkg.sv
// Shared types and helpers for the mixsx32 / unmixsx32 key-mixing pair.
package unmix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WORD32 = 32;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/unmixsx32_if.sv
// Operand/result bundle for unmixsx32: start request, mixed state, key words, indices and status.
interface unmixsx32_if #(
  parameter int CWORDS64 = 2,
  parameter int XWORDS32 = 2
);
  import unmix_pkg::*;

  localparam int IDX_WIDTH = idx_width(XWORDS32);

  logic                          start;
  logic [CWORDS64*64-1:0]        cin;
  logic [XWORDS32*WORD32-1:0]    x;
  logic [CWORDS64*IDX_WIDTH-1:0] d;
  logic [CWORDS64*64-1:0]        c_out;
  logic                          busy;
  logic                          done;
  logic                          data_rdy;
  logic                          idx_err;

  modport master (
    output start, cin, x, d,
    input  c_out, busy, done, data_rdy, idx_err
  );

  modport slave (
    input  start, cin, x, d,
    output c_out, busy, done, data_rdy, idx_err
  );

endinterface

// File: rtl/unmixsx32_word32_select.sv
// Combinational 32-bit slice select by index, with a flag for indices past the last word.
module word32_select
  import unmix_pkg::*;
#(
  parameter int NWORDS = 2,
  localparam int IW    = idx_width(NWORDS)
) (
  input  logic [NWORDS*WORD32-1:0] words,
  input  logic [IW-1:0]            idx,
  output logic [WORD32-1:0]        word,
  output logic                     oor
);

  logic [WORD32-1:0] slices [NWORDS];

  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slice
      assign slices[gi] = words[gi*WORD32 +: WORD32];
    end
  endgenerate

  // Out-of-range indices yield zero so the caller never sees an undefined slice.
  always_comb begin
    oor  = (int'(idx) >= NWORDS);
    word = '0;
    if (!oor) begin
      word = slices[idx];
    end
  end

endmodule

// File: rtl/unmixsx32.sv
// Inverse key mix: XORs the low half of each 64-bit state word with an indexed key word, one word per cycle.
module unmixsx32
  import unmix_pkg::*;
#(
  parameter int CWORDS64 = 2,
  parameter int XWORDS32 = 2
) (
  input logic        clk,
  input logic        reset,
  unmixsx32_if.slave bus
);

  localparam int IDX_WIDTH = idx_width(XWORDS32);
  localparam int CNT_W     = $clog2(CWORDS64) + 1;

  state_t                        state_reg, state_next;
  logic [CWORDS64*64-1:0]        cin_r, c_out_reg;
  logic [XWORDS32*WORD32-1:0]    x_r;
  logic [CWORDS64*IDX_WIDTH-1:0] d_r;
  logic [CNT_W-1:0]              cnt_reg;
  logic                          data_rdy_reg, idx_err_reg;
  logic [IDX_WIDTH-1:0]          d_fields [CWORDS64];
  logic [IDX_WIDTH-1:0]          d_k;
  logic [WORD32-1:0]             x_sel;
  logic                          x_oor;
  logic                          last_word;

  generate
    for (genvar gi = 0; gi < CWORDS64; gi++) begin : g_dfield
      assign d_fields[gi] = d_r[gi*IDX_WIDTH +: IDX_WIDTH];
    end
  endgenerate

  always_comb begin
    d_k = '0;
    for (int i = 0; i < CWORDS64; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        d_k = d_fields[i];
      end
    end
  end

  word32_select #(.NWORDS(XWORDS32)) u_sel (
    .words (x_r),
    .idx   (d_k),
    .word  (x_sel),
    .oor   (x_oor)
  );

  assign last_word = (cnt_reg == CNT_W'(CWORDS64 - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (last_word) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cin_r        <= '0;
      x_r          <= '0;
      d_r          <= '0;
      c_out_reg    <= '0;
      cnt_reg      <= '0;
      data_rdy_reg <= 1'b0;
      idx_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cin_r        <= bus.cin;
            x_r          <= bus.x;
            d_r          <= bus.d;
            data_rdy_reg <= 1'b0;
            idx_err_reg  <= 1'b0;
          end
        end
        LOAD: begin
          cnt_reg   <= '0;
          c_out_reg <= cin_r;
        end
        RUN: begin
          // A bad index leaves the word exactly as loaded, upper and lower halves.
          for (int i = 0; i < CWORDS64; i++) begin
            if (cnt_reg == CNT_W'(i) && !x_oor) begin
              c_out_reg[i*64 +: WORD32] <= cin_r[i*64 +: WORD32] ^ x_sel;
            end
          end
          if (x_oor) begin
            idx_err_reg <= 1'b1;
          end
          if (last_word) begin
            data_rdy_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.c_out    = c_out_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.data_rdy = data_rdy_reg;
  assign bus.idx_err  = idx_err_reg;

endmodule

// File: tb/tb_unmixsx32.sv
// Directed bench for unmixsx32 across three configurations sharing one clock and reset.
module tb_unmixsx32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  unmixsx32_if #(.CWORDS64(2), .XWORDS32(2)) if_a ();
  unmixsx32_if #(.CWORDS64(2), .XWORDS32(3)) if_b ();
  unmixsx32_if #(.CWORDS64(1), .XWORDS32(2)) if_c ();

  unmixsx32 #(.CWORDS64(2), .XWORDS32(2)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  unmixsx32 #(.CWORDS64(2), .XWORDS32(3)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  unmixsx32 #(.CWORDS64(1), .XWORDS32(2)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

  localparam logic [127:0] BASIC_CIN = 128'h00000003_AAAA5555_00000002_12345678;
  localparam logic [63:0]  BASIC_X   = {32'hAAAA5555, 32'h12345678};
  localparam logic [1:0]   BASIC_D   = 2'b10;
  localparam logic [127:0] BASIC_EXP = 128'h00000003_00000000_00000002_00000000;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each run task returns at the negedge where done is seen (or after the cycle budget).
  task automatic run_a(input logic [127:0] c, input logic [63:0] xv, input logic [1:0] dv,
                       output int cyc);
    if_a.cin = c; if_a.x = xv; if_a.d = dv; if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    cyc = 1;
    while (if_a.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_b(input logic [127:0] c, input logic [95:0] xv, input logic [3:0] dv,
                       output int cyc, output logic err_c1);
    if_b.cin = c; if_b.x = xv; if_b.d = dv; if_b.start = 1'b1;
    @(negedge clk);
    if_b.start = 1'b0;
    err_c1 = if_b.idx_err;
    cyc = 1;
    while (if_b.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_c(input logic [63:0] c, input logic [63:0] xv, input logic dv,
                       output int cyc);
    if_c.cin = c; if_c.x = xv; if_c.d = dv; if_c.start = 1'b1;
    @(negedge clk);
    if_c.start = 1'b0;
    cyc = 1;
    while (if_c.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int           cyc;
    int           dones;
    logic         err_c1;
    logic [127:0] r_cin, mid;
    logic [63:0]  r_x;
    logic [1:0]   r_d;

    reset = 1'b1;
    if_a.start = 1'b0; if_a.cin = '0; if_a.x = '0; if_a.d = '0;
    if_b.start = 1'b0; if_b.cin = '0; if_b.x = '0; if_b.d = '0;
    if_c.start = 1'b0; if_c.cin = '0; if_c.x = '0; if_c.d = '0;
    repeat (3) @(negedge clk);

    check("rst_c_out",    if_a.c_out,    128'h0);
    check("rst_busy",     if_a.busy,     128'h0);
    check("rst_done",     if_a.done,     128'h0);
    check("rst_data_rdy", if_a.data_rdy, 128'h0);
    check("rst_idx_err",  if_a.idx_err,  128'h0);
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word unmix
    run_a(BASIC_CIN, BASIC_X, BASIC_D, cyc);
    check("basic_latency",  cyc,           128'd4);
    check("basic_c_out",    if_a.c_out,    BASIC_EXP);
    check("basic_idx_err",  if_a.idx_err,  128'h0);
    check("basic_data_rdy", if_a.data_rdy, 128'h1);
    @(negedge clk);
    check("basic_done_pulse", if_a.done,   128'h0);
    repeat (3) @(negedge clk);
    check("basic_rdy_hold",  if_a.data_rdy, 128'h1);
    check("basic_idle",      if_a.busy,     128'h0);
    check("basic_c_out_hold", if_a.c_out,   BASIC_EXP);

    // Round trip: unmixing twice with the same key restores the input
    r_cin = {$urandom, $urandom, $urandom, $urandom};
    r_x   = {$urandom, $urandom};
    r_d   = 2'($urandom_range(0, 3));
    run_a(r_cin, r_x, r_d, cyc);
    check("rt1_latency", cyc, 128'd4);
    mid = if_a.c_out;
    @(negedge clk);
    run_a(mid, r_x, r_d, cyc);
    check("rt2_latency", cyc, 128'd4);
    check("rt_c_out",    if_a.c_out, r_cin);
    @(negedge clk);

    // start during RUN with a different cin is ignored
    if_a.cin = BASIC_CIN; if_a.x = BASIC_X; if_a.d = BASIC_D; if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    check("busy_c1_busy",     if_a.busy,     128'h1);
    check("busy_c1_data_rdy", if_a.data_rdy, 128'h0);
    @(negedge clk);
    if_a.start = 1'b1; if_a.cin = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    @(negedge clk);
    if_a.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_a.done === 1'b1) dones++;
      @(negedge clk);
    end
    check("busy_done_count", dones,      128'd1);
    check("busy_c_out",      if_a.c_out, BASIC_EXP);

    // Reset in the RUN cycle with cnt=1 discards the partial result
    if_a.cin = BASIC_CIN; if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_c_out",    if_a.c_out,    128'h0);
    check("mrst_busy",     if_a.busy,     128'h0);
    check("mrst_data_rdy", if_a.data_rdy, 128'h0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (if_a.done === 1'b1) dones++;
      @(negedge clk);
    end
    check("mrst_no_done", dones, 128'd0);
    run_a(BASIC_CIN, BASIC_X, BASIC_D, cyc);
    check("mrst_rerun_latency", cyc,        128'd4);
    check("mrst_rerun_c_out",   if_a.c_out, BASIC_EXP);
    @(negedge clk);

    // Out-of-range index on word1 with three key words
    run_b(128'h89ABCDEF_01234567_FFFF0000_0F0F0F0F,
          {32'hCAFEBABE, 32'hDEADBEEF, 32'h11111111}, {2'd3, 2'd1}, cyc, err_c1);
    check("oor_latency",  cyc,            128'd4);
    check("oor_c_out",    if_b.c_out,     128'h89ABCDEF_01234567_FFFF0000_D1A2B1E0);
    check("oor_idx_err",  if_b.idx_err,   128'h1);
    check("oor_data_rdy", if_b.data_rdy,  128'h1);
    @(negedge clk);
    check("oor_err_sticky", if_b.idx_err, 128'h1);
    run_b(128'h89ABCDEF_01234567_FFFF0000_0F0F0F0F,
          {32'hCAFEBABE, 32'hDEADBEEF, 32'h11111111}, 4'b0000, cyc, err_c1);
    check("oor_err_cleared", err_c1,       128'h0);
    check("inr_c_out",       if_b.c_out,   128'h89ABCDEF_10325476_FFFF0000_1E1E1E1E);
    check("inr_idx_err",     if_b.idx_err, 128'h0);
    @(negedge clk);

    // Single-word configuration
    run_c(64'h0123456789ABCDEF, {32'hFFFFFFFF, 32'h00000000}, 1'b1, cyc);
    check("single_latency", cyc,           128'd3);
    check("single_c_out",   if_c.c_out,    128'h0123456776543210);
    check("single_idx_err", if_c.idx_err,  128'h0);
    @(negedge clk);
    check("single_done_pulse", if_c.done,  128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
